// File: rtl/countdown_part.sv
// BCD MM:SS count-down timer with preset, pause/resume and completion flag.
// Optional AUTO_RELOAD_EN: reload the last preset on reaching 00:00 and keep running.
module countdown_part #(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] set_mt,
  input  logic [3:0] set_mo,
  input  logic [3:0] set_st,
  input  logic [3:0] set_so,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min_ten,
  output logic [3:0] min_one,
  output logic [3:0] sec_ten,
  output logic [3:0] sec_one,
  output logic       seclock,
  output logic       zero,
  output logic       running,
  output logic       done
);

  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_d);
    clamp_digit = (d > max_d) ? max_d : d;
  endfunction

  // Packed {mt, mo, st, so}; the borrow ripples from seconds-ones upward.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    logic       b0, b1, b2;
    mt = t[15:12];
    mo = t[11:8];
    st = t[7:4];
    so = t[3:0];
    if (so == 4'd0) begin so = 4'd9; b0 = 1'b1; end
    else begin so = so - 4'd1; b0 = 1'b0; end
    if (b0 && (st == 4'd0)) begin st = 4'd5; b1 = 1'b1; end
    else if (b0) begin st = st - 4'd1; b1 = 1'b0; end
    else begin b1 = 1'b0; end
    if (b1 && (mo == 4'd0)) begin mo = 4'd9; b2 = 1'b1; end
    else if (b1) begin mo = mo - 4'd1; b2 = 1'b0; end
    else begin b2 = 1'b0; end
    if (b2) begin mt = mt - 4'd1; end
    else begin mt = mt; end
    bcd_dec = {mt, mo, st, so};
  endfunction

  state_t          state_r, state_nx_s;
  logic [DW-1:0]   div_r, div_nx_s;
  logic [15:0]     time_r, time_dec_s, load_val_s;
  logic            tick_s, reload_s;
  logic            seclock_r, running_r, done_r;
`ifdef AUTO_RELOAD_EN
  logic [15:0]     shadow_r;
`endif

  assign time_dec_s = bcd_dec(time_r);
  assign load_val_s = {clamp_digit(set_mt, 4'd9), clamp_digit(set_mo, 4'd9),
                       clamp_digit(set_st, 4'd5), clamp_digit(set_so, 4'd9)};

  assign min_ten = time_r[15:12];
  assign min_one = time_r[11:8];
  assign sec_ten = time_r[7:4];
  assign sec_one = time_r[3:0];
  assign zero    = (time_r == 16'd0);
  assign seclock = seclock_r;
  assign running = running_r;
  assign done    = done_r;

  // Next-state, divider and tick decode; load beats stop beats start.
  always_comb begin
    state_nx_s = state_r;
    div_nx_s   = div_r;
    tick_s     = 1'b0;
    reload_s   = 1'b0;
    if (load) begin
      state_nx_s = IDLE;
      div_nx_s   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !zero) begin
            state_nx_s = RUN;
            div_nx_s   = '0;
          end else begin
            state_nx_s = IDLE;
          end
        end
        RUN: begin
          if (stop) begin
            state_nx_s = PAUSE;
          end else if (div_r == DIV_LAST) begin
            div_nx_s = '0;
            tick_s   = 1'b1;
            if (time_dec_s == 16'd0) begin
`ifdef AUTO_RELOAD_EN
              if (shadow_r != 16'd0) begin
                reload_s   = 1'b1;
                state_nx_s = RUN;
              end else begin
                state_nx_s = DONE;
              end
`else
              state_nx_s = DONE;
`endif
            end else begin
              state_nx_s = RUN;
            end
          end else begin
            div_nx_s = div_r + DIV_ONE;
          end
        end
        PAUSE: begin
          if (stop) begin
            state_nx_s = PAUSE;
          end else if (start) begin
            state_nx_s = RUN;
          end else begin
            state_nx_s = PAUSE;
          end
        end
        DONE: begin
          if (stop) begin
            state_nx_s = DONE;
          end else if (start) begin
            state_nx_s = IDLE;
          end else begin
            state_nx_s = DONE;
          end
        end
        default: begin
          state_nx_s = IDLE;
          div_nx_s   = '0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Divider, digits and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_r     <= '0;
      time_r    <= 16'd0;
      seclock_r <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      div_r     <= div_nx_s;
      seclock_r <= tick_s;
      running_r <= (state_nx_s == RUN);
      done_r    <= (state_nx_s == DONE) || reload_s;
      if (load) begin
        time_r <= load_val_s;
      end else if (reload_s) begin
`ifdef AUTO_RELOAD_EN
        time_r <= shadow_r;
`else
        time_r <= time_r;
`endif
      end else if (tick_s) begin
        time_r <= time_dec_s;
      end else begin
        time_r <= time_r;
      end
    end
  end

`ifdef AUTO_RELOAD_EN
  // Shadow copy of the last clamped preset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_r <= 16'd0;
    end else if (load) begin
      shadow_r <= load_val_s;
    end else begin
      shadow_r <= shadow_r;
    end
  end
`endif

endmodule

// File: tb/tb_countdown_part.sv
// Directed self-checking bench for countdown_part (DIV=10).
module tb_countdown_part;

  logic       clk, rst, load, start, stop;
  logic [3:0] set_mt, set_mo, set_st, set_so;
  logic [3:0] min_ten, min_one, sec_ten, sec_one;
  logic       seclock, zero, running, done;
  logic [15:0] t_s;

  int checks_total;
  int checks_passed;

  countdown_part #(.DIV(10)) dut (
    .clk(clk), .rst(rst), .load(load),
    .set_mt(set_mt), .set_mo(set_mo), .set_st(set_st), .set_so(set_so),
    .start(start), .stop(stop),
    .min_ten(min_ten), .min_one(min_one), .sec_ten(sec_ten), .sec_one(sec_one),
    .seclock(seclock), .zero(zero), .running(running), .done(done)
  );

  assign t_s = {min_ten, min_one, sec_ten, sec_one};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      checks_passed++;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic with_start);
    {set_mt, set_mo, set_st, set_so} = v;
    load  = 1'b1;
    start = with_start;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
  endtask

  task automatic pulse(input logic p_start, input logic p_stop);
    start = p_start;
    stop  = p_stop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  logic [15:0] seq12 [12] = '{16'h0011, 16'h0010, 16'h0009, 16'h0008, 16'h0007, 16'h0006,
                              16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};

  initial begin
    checks_total = 0;
    checks_passed = 0;
    rst = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    {set_mt, set_mo, set_st, set_so} = 16'h0000;
    #3;
    check("reset_digits", t_s, 16'h0000);
    check("reset_flags", {12'd0, zero, running, done, seclock}, 16'h0008);
    @(negedge clk);
    rst = 1'b1;
    cycles(2);

    // 00:12 runs to completion, one tick per 10 clocks
    do_load(16'h0012, 1'b0);
    check("load_0012", t_s, 16'h0012);
    pulse(1'b1, 1'b0);
    check("run_after_start", {15'd0, running}, 16'd1);
    for (int k = 0; k < 12; k++) begin
      cycles(9);
      if (k == 0) check("seclock_low_mid", {15'd0, seclock}, 16'd0);
      cycles(1);
      check($sformatf("tick%0d_digits", k + 1), t_s, seq12[k]);
      if (k == 0) check("seclock_high", {15'd0, seclock}, 16'd1);
      if (k == 10) check("not_done_0001", {15'd0, done}, 16'd0);
    end
    check("done_at_120", {13'd0, zero, running, done}, 16'h0005);
    cycles(12);
    check("done_hold", {12'd0, zero, running, done, seclock}, 16'h000A);
    check("done_digits", t_s, 16'h0000);
    pulse(1'b1, 1'b0);
    check("done_ack_idle", {14'd0, running, done}, 16'h0000);

    // 10:00 full borrow, then pause/resume keeps the divider phase
    do_load(16'h1000, 1'b0);
    pulse(1'b1, 1'b0);
    cycles(10);
    check("borrow_0959", t_s, 16'h0959);
    cycles(3);
    pulse(1'b0, 1'b1);
    check("paused", {15'd0, running}, 16'd0);
    cycles(37);
    check("pause_hold", t_s, 16'h0959);
    pulse(1'b1, 1'b0);
    check("resumed", {15'd0, running}, 16'd1);
    cycles(6);
    check("resume_no_tick_yet", {15'd0, seclock}, 16'd0);
    check("resume_digits_held", t_s, 16'h0959);
    cycles(1);
    check("resume_tick", {15'd0, seclock}, 16'd1);
    check("resume_0958", t_s, 16'h0958);

    // coinciding pulses
    pulse(1'b1, 1'b1);
    check("start_stop_pause", {15'd0, running}, 16'd0);
    pulse(1'b1, 1'b0);
    check("rerun", {15'd0, running}, 16'd1);
    do_load(16'hCF7B, 1'b1);
    check("clamp_9959", t_s, 16'h9959);
    check("load_start_idle", {15'd0, running}, 16'd0);
    do_load(16'h0000, 1'b0);
    pulse(1'b1, 1'b0);
    check("start_at_zero", {14'd0, zero, running}, 16'h0002);

    // asynchronous reset mid-count
    do_load(16'h0123, 1'b0);
    pulse(1'b1, 1'b0);
    cycles(5);
    #2 rst = 1'b0;
    #1;
    check("async_rst_digits", t_s, 16'h0000);
    check("async_rst_flags", {13'd0, zero, running, done}, 16'h0004);
    @(negedge clk);
    rst = 1'b1;
    cycles(1);

    // 00:02 completion: auto reload or plain DONE
    do_load(16'h0002, 1'b0);
    pulse(1'b1, 1'b0);
    cycles(10);
    check("ar_0001", t_s, 16'h0001);
    cycles(10);
`ifdef AUTO_RELOAD_EN
    check("ar_reload", t_s, 16'h0002);
    check("ar_pulse", {14'd0, running, done}, 16'h0003);
    cycles(1);
    check("ar_pulse_end", {14'd0, running, done}, 16'h0002);
`else
    check("end_0000", t_s, 16'h0000);
    check("end_done", {14'd0, running, done}, 16'h0001);
    cycles(1);
    check("end_done_hold", {14'd0, running, done}, 16'h0001);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
